// File: rtl/fetch_req_unit.sv
// Pre-IF fetch-request stage: owns the fetch PC, issues one instruction-bus request at a time, and buffers the returned word for IF.
// Latency: request in the first REQ cycle; the word is registered, so fs_valid rises the cycle after data_ok.
// Backpressure: without if_allowin the buffered word is held and no new request is issued; a redirect drops it.
//
// Ports:
//   clk, resetn                        clock, asynchronous active-low reset
//   flush/flush_target                 exception/ertn redirect (highest priority)
//   br_flush/br_target                 ID branch redirect
//   if_allowin                         IF accepts the offered instruction
//   inst_sram_*                        SRAM-like instruction bus (read-only, word size)
//   fs_valid/fs_pc/fs_inst/fs_adef     instruction offered to IF
module fetch_req_unit #(
    parameter logic [31:0] PC_INIT = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [31:0] flush_target,
    input  logic        br_flush,
    input  logic [31:0] br_target,
    input  logic        if_allowin,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic        fs_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_adef
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        cancel, cancel_nxt;
    logic [31:0] hold_inst, hold_inst_nxt;
    logic        hold_adef, hold_adef_nxt;

    logic        redirect;
    logic [31:0] redirect_pc;

    assign redirect    = flush | br_flush;
    assign redirect_pc = flush ? flush_target : br_target;

    // Write-side of the bus is never used by the fetch stage.
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'h0;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            pc        <= PC_INIT;
            cancel    <= 1'b0;
            hold_inst <= 32'h0;
            hold_adef <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            cancel    <= cancel_nxt;
            hold_inst <= hold_inst_nxt;
            hold_adef <= hold_adef_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        cancel_nxt    = cancel;
        hold_inst_nxt = hold_inst;
        hold_adef_nxt = hold_adef;

        // The stale response of a cancelled request retires here whatever the
        // state; its data is never looked at.
        if (inst_sram_data_ok && cancel) begin
            cancel_nxt = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (redirect) begin
                    // req is masked by the redirect, so an addr_ok seen now
                    // did not start a transaction.
                    pc_nxt    = redirect_pc;
                    state_nxt = ST_REQ;
                end else if (pc[1:0] != 2'b00) begin
                    hold_adef_nxt = 1'b1;
                    hold_inst_nxt = 32'h0;
                    state_nxt     = ST_HOLD;
                end else if (inst_sram_req && inst_sram_addr_ok) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = ST_REQ;
                    // Response still in flight: remember to swallow it.
                    if (!inst_sram_data_ok) begin
                        cancel_nxt = 1'b1;
                    end
                end else if (inst_sram_data_ok && !cancel) begin
                    hold_inst_nxt = inst_sram_rdata;
                    hold_adef_nxt = 1'b0;
                    state_nxt     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = ST_REQ;
                end else if (fs_valid && if_allowin) begin
                    pc_nxt    = pc + 32'd4;
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        inst_sram_req  = (state == ST_REQ) && !cancel && (pc[1:0] == 2'b00) && !redirect;
        inst_sram_addr = pc;
        // A redirect masks the offer so IF never consumes a wrong-path word.
        fs_valid       = (state == ST_HOLD) && !redirect;
        fs_pc          = pc;
        fs_inst        = hold_inst;
        fs_adef        = hold_adef;
    end

endmodule

// File: doc/fetch_req_unit.md
Name: fetch_req_unit

Overview:
- Pre-IF fetch-request stage: owns the fetch PC and drives the SRAM-like instruction bus (req/addr_ok/data_ok).
- Holds at most one outstanding request and buffers the returned word in a one-entry holding register.
- Presents {pc, inst, adef} to IF with a valid/allowin handshake.
- Cancels in-flight requests on exception flush or ID branch redirect, discarding their stale responses.

Parameters:
PC_INIT, 32'h1c000000, address of the first fetch after reset.

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
flush  in  1  exception/ertn redirect, highest priority
flush_target  in  32  redirect PC for flush
br_flush  in  1  ID branch redirect
br_target  in  32  redirect PC for br_flush
if_allowin  in  1  IF accepts an instruction this cycle
inst_sram_req  out  1  request valid
inst_sram_wr  out  1  constant 0
inst_sram_size  out  2  constant 2'b10
inst_sram_wstrb  out  4  constant 0
inst_sram_wdata  out  32  constant 0
inst_sram_addr  out  32  request address (= fetch PC)
inst_sram_addr_ok  in  1  address handshake
inst_sram_data_ok  in  1  data return
inst_sram_rdata  in  32  returned instruction
fs_valid  out  1  instruction available to IF
fs_pc  out  32  PC of offered instruction
fs_inst  out  32  offered instruction (0 when fs_adef)
fs_adef  out  1  fetch-address misalignment exception

Behaviour:
- Registers: pc, state {IDLE, REQ, WAIT, HOLD}, cancel (1 bit), hold_inst, hold_adef.
- Reset (resetn=0, async):
  - state=IDLE, pc=PC_INIT, cancel=0, hold_inst=0, hold_adef=0.
  - All outputs read as inst_sram_req=0, inst_sram_addr=PC_INIT, fs_valid=0, fs_pc=PC_INIT, fs_inst=0, fs_adef=0.
- IDLE -> REQ on the first clock edge after reset release.
- redirect = flush | br_flush. Next PC on redirect = flush ? flush_target : br_target.
- inst_sram_req = (state==REQ) & ~cancel & (pc[1:0]==0) & ~redirect.
- inst_sram_addr = pc.
- REQ:
  - pc[1:0]!=0: no request issued; hold_adef=1, hold_inst=0, go HOLD.
  - req & addr_ok: go WAIT.
  - cancel=1: req is held low. A data_ok in this state clears cancel, and the response is dropped.
- WAIT:
  - data_ok & ~cancel: hold_inst=rdata, hold_adef=0, go HOLD.
  - Returned data is always registered. Earliest fs_valid is the cycle after data_ok.
- HOLD:
  - fs_valid = (state==HOLD) & ~redirect.
  - fs_pc=pc, fs_inst=hold_inst, fs_adef=hold_adef.
  - fs_valid & if_allowin: pc<=pc+4 (32-bit wrap), go REQ.
  - Otherwise hold all values.
- Redirect (any state except IDLE; overrides every other transition): pc<=target, next state REQ. Additionally:
  - REQ with addr_ok in the same cycle: the handshake is not taken, because req is masked by redirect. cancel unchanged.
  - WAIT without data_ok: cancel<=1 and the outstanding response is discarded later. WAIT with data_ok in the same cycle: data dropped, cancel stays 0.
  - HOLD: buffered word dropped. The redirect also masks fs_valid, so IF never takes a wrong-path word.
- data_ok while cancel=1 (any state): cancel<=0, rdata ignored.
- Simultaneous data_ok for a stale request and a new redirect: cancel is cleared by the data_ok and is not set again. Only one request is ever outstanding.
- Invariant: at most one request is outstanding, and req is never high while cancel=1.
- Reset asserted mid-transaction: state returns to IDLE immediately. Any response arriving after reset release is undefined bus behaviour and is not required to be handled.

Test Plan:
1. Reset release, addr_ok=1 immediately, data_ok one cycle later with rdata=32'h02800421, if_allowin=1.
   - Required: req asserted in cycle 1 with addr 32'h1c000000.
   - Required: fs_valid=1 with fs_pc=32'h1c000000 and fs_inst=32'h02800421 in the cycle after data_ok.
   - Required: next req addr is 32'h1c000004.
2. Backpressure: if_allowin=0 for 5 cycles while in HOLD.
   - Required: fs_valid stays 1 and fs_pc/fs_inst stay stable; no new req.
   - Required: when if_allowin=1, next req addr = fs_pc+4.
3. br_flush=1 with br_target=32'h1c000100 while in WAIT. Stale data_ok (rdata=32'hdeadbeef) arrives 3 cycles later.
   - Required: req stays low until that data_ok, and the word is never presented.
   - Required: next req addr is 32'h1c000100.
4. flush and br_flush in the same cycle (flush_target=32'h1c008000, br_target=32'h1c000200) while in HOLD.
   - Required: fs_valid=0 that cycle; next req addr is 32'h1c008000.
5. flush_target=32'h1c000002.
   - Required: no req is issued.
   - Required: next cycle fs_valid=1, fs_adef=1, fs_inst=0, fs_pc=32'h1c000002.
6. resetn driven low asynchronously while in WAIT.
   - Required: req=0, fs_valid=0, fs_pc=PC_INIT without waiting for a clock edge.
   - Required: after release, the fetch sequence restarts from 32'h1c000000.
